// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-memory bus bridge:
//   - access-size encodings carried on the core's data_mask port
//   - bridge_state_t, the bridge FSM state type
//   - is_word(), which folds the reserved mask encoding into word accesses
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam logic [1:0] MASK_BYTE = 2'b00;
    localparam logic [1:0] MASK_HALF = 2'b01;
    localparam logic [1:0] MASK_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } bridge_state_t;

    // Encoding 2'b11 is reserved and behaves as a word access, so any mask
    // with bit 1 set is a word.
    function automatic logic is_word(input logic [1:0] mask);
        return mask[1];
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// -----------------------------------------------------------------------------
// dmem_lane_align
// Purely combinational byte-lane logic for the bridge.
// Store side (driven from the live core request):
//   wr_off, wr_mask   byte offset addr[1:0] and access size of the request
//   store_data        LSB-justified store data
//   wstrb             byte strobes for the addressed lanes
//   wdata             store data replicated across all lanes
//   misaligned        half on an odd address, or word not on a word boundary
// Load side (driven from the offset/size captured when the load was issued):
//   rd_off, rd_mask   byte offset and access size of the outstanding load
//   load_word         raw 32-bit bus response word
//   load_data         addressed bytes shifted to the LSBs, zero-extended
// -----------------------------------------------------------------------------
module dmem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  wr_off,
    input  logic [1:0]  wr_mask,
    input  logic [31:0] store_data,
    input  logic [1:0]  rd_off,
    input  logic [1:0]  rd_mask,
    input  logic [31:0] load_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misaligned,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        wstrb      = 4'b1111;
        wdata      = store_data;
        misaligned = 1'b0;
        if (is_word(wr_mask)) begin
            misaligned = (wr_off != 2'b00);
        end else if (wr_mask == MASK_HALF) begin
            wstrb      = 4'b0011 << wr_off;
            wdata      = {2{store_data[15:0]}};
            misaligned = wr_off[0];
        end else begin
            wstrb      = 4'b0001 << wr_off;
            wdata      = {4{store_data[7:0]}};
        end
    end

    always_comb begin
        shifted = load_word >> {rd_off, 3'b000};
        if (is_word(rd_mask)) begin
            load_data = shifted;
        end else if (rd_mask == MASK_HALF) begin
            load_data = {16'h0000, shifted[15:0]};
        end else begin
            load_data = {24'h000000, shifted[7:0]};
        end
    end

endmodule

// File: rtl/dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// dmem_bus_bridge
// Bridges the core data-memory port onto a valid/ready bus with byte strobes.
// Aligned requests become one bus transfer; misaligned requests are dropped
// and flagged; transfers stuck for TIMEOUT_CYCLES in REQ or RESP are aborted
// and flagged. o_stall freezes the core until the bridge reaches DONE, where
// it is low for one cycle so the core can retire the access.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_addr, i_write_data     core byte address and LSB-justified store data
//   i_read_en, i_write_en    load / store request (store wins if both high)
//   i_data_mask              access size (byte/half/word, 11 = word)
//   o_read_data              aligned, zero-extended load result (held)
//   o_stall                  core hold
//   o_misaligned, o_bus_error  single-cycle event pulses
//   o_bus_*/i_bus_*          system bus request and read response channels
// -----------------------------------------------------------------------------
module dmem_bus_bridge
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_write_data,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [1:0]  i_data_mask,
    output logic [31:0] o_read_data,
    output logic        o_stall,
    output logic        o_misaligned,
    output logic        o_bus_error,
    output logic        o_bus_valid,
    input  logic        i_bus_ready,
    output logic [31:0] o_bus_addr,
    output logic        o_bus_we,
    output logic [3:0]  o_bus_wstrb,
    output logic [31:0] o_bus_wdata,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    // The counter starts at 0 on entry, so the TIMEOUT_CYCLES-th waiting
    // cycle is the one where it reads TIMEOUT_CYCLES-1.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    bridge_state_t   state;
    bridge_state_t   state_next;
    logic [TO_W-1:0] to_cnt;
    logic [1:0]      rsp_off;
    logic [1:0]      rsp_mask;
    logic            req;
    logic            timed_out;
    logic [3:0]      lane_wstrb;
    logic [31:0]     lane_wdata;
    logic [31:0]     lane_rdata;
    logic            lane_misaligned;

    assign req = i_read_en | i_write_en;

    dmem_lane_align u_lane_align (
        .wr_off     (i_addr[1:0]),
        .wr_mask    (i_data_mask),
        .store_data (i_write_data),
        .rd_off     (rsp_off),
        .rd_mask    (rsp_mask),
        .load_word  (i_bus_rdata),
        .wstrb      (lane_wstrb),
        .wdata      (lane_wdata),
        .misaligned (lane_misaligned),
        .load_data  (lane_rdata)
    );

    always_comb begin
        state_next = state;
        o_stall    = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    o_stall    = 1'b1;
                    state_next = lane_misaligned ? DONE : REQ;
                end
            end
            REQ: begin
                o_stall = 1'b1;
                if (i_bus_ready) begin
                    state_next = o_bus_we ? DONE : RESP;
                end else if (to_cnt == TO_LAST) begin
                    timed_out  = 1'b1;
                    state_next = DONE;
                end
            end
            RESP: begin
                o_stall = 1'b1;
                if (i_bus_rvalid) begin
                    state_next = DONE;
                end else if (to_cnt == TO_LAST) begin
                    timed_out  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register updates from the same pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt       <= '0;
            rsp_off      <= '0;
            rsp_mask     <= '0;
            o_read_data  <= '0;
            o_misaligned <= 1'b0;
            o_bus_error  <= 1'b0;
            o_bus_valid  <= 1'b0;
            o_bus_addr   <= '0;
            o_bus_we     <= 1'b0;
            o_bus_wstrb  <= '0;
            o_bus_wdata  <= '0;
        end else begin
            o_misaligned <= 1'b0;
            o_bus_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        to_cnt <= '0;
                        if (lane_misaligned) begin
                            o_misaligned <= 1'b1;
                            o_read_data  <= '0;
                        end else begin
                            o_bus_valid <= 1'b1;
                            o_bus_addr  <= {i_addr[31:2], 2'b00};
                            o_bus_we    <= i_write_en;
                            o_bus_wstrb <= i_write_en ? lane_wstrb : 4'b0000;
                            o_bus_wdata <= lane_wdata;
                            rsp_off     <= i_addr[1:0];
                            rsp_mask    <= i_data_mask;
                        end
                    end
                end
                REQ: begin
                    if (i_bus_ready) begin
                        o_bus_valid <= 1'b0;
                        to_cnt      <= '0;
                    end else if (timed_out) begin
                        o_bus_valid <= 1'b0;
                        o_bus_error <= 1'b1;
                        o_read_data <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (i_bus_rvalid) begin
                        o_read_data <= lane_rdata;
                    end else if (timed_out) begin
                        o_bus_error <= 1'b1;
                        o_read_data <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_dmem_bus_bridge
// Self-checking bench for dmem_bus_bridge built with TIMEOUT_CYCLES = 4.
// A fixed vector table with hand-derived expectations is followed by
// randomized transactions whose expectations come from a transaction-level
// model, plus a hand-written reset-during-RESP sequence.
// -----------------------------------------------------------------------------
module tb_dmem_bus_bridge;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_addr;
    logic [31:0] i_write_data;
    logic        i_read_en;
    logic        i_write_en;
    logic [1:0]  i_data_mask;
    logic [31:0] o_read_data;
    logic        o_stall;
    logic        o_misaligned;
    logic        o_bus_error;
    logic        o_bus_valid;
    logic        i_bus_ready;
    logic [31:0] o_bus_addr;
    logic        o_bus_we;
    logic [3:0]  o_bus_wstrb;
    logic [31:0] o_bus_wdata;
    logic        i_bus_rvalid;
    logic [31:0] i_bus_rdata;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_hold;

    always #5 clk = ~clk;

    dmem_bus_bridge #(.TIMEOUT_CYCLES(T)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_addr       (i_addr),
        .i_write_data (i_write_data),
        .i_read_en    (i_read_en),
        .i_write_en   (i_write_en),
        .i_data_mask  (i_data_mask),
        .o_read_data  (o_read_data),
        .o_stall      (o_stall),
        .o_misaligned (o_misaligned),
        .o_bus_error  (o_bus_error),
        .o_bus_valid  (o_bus_valid),
        .i_bus_ready  (i_bus_ready),
        .o_bus_addr   (o_bus_addr),
        .o_bus_we     (o_bus_we),
        .o_bus_wstrb  (o_bus_wstrb),
        .o_bus_wdata  (o_bus_wdata),
        .i_bus_rvalid (i_bus_rvalid),
        .i_bus_rdata  (i_bus_rdata)
    );

    // One transaction: core request, bus behaviour (rdy = cycles valid waits
    // before ready, rv = RESP cycles before rvalid), and expected results.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rd;
        logic        wr;
        logic [1:0]  mask;
        int          rdy;
        int          rv;
        logic [31:0] rdata;
        int          stall;
        int          vcyc;
        logic        mis;
        logic        err;
        logic [31:0] baddr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] rdv;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] addr, data, input logic rd, wr,
                                input logic [1:0] mask, input int rdy, rv,
                                input logic [31:0] rdata, input int stall, vcyc,
                                input logic mis, err, input logic [31:0] baddr,
                                input logic [3:0] strb, input logic [31:0] wdata, rdv);
        vec_t v;
        v.addr = addr;  v.data = data;   v.rd = rd;     v.wr = wr;     v.mask = mask;
        v.rdy = rdy;    v.rv = rv;       v.rdata = rdata;
        v.stall = stall; v.vcyc = vcyc;  v.mis = mis;   v.err = err;
        v.baddr = baddr; v.we = wr;      v.strb = strb; v.wdata = wdata; v.rdv = rdv;
        return v;
    endfunction

    // Transaction-level reference: access size in bytes, alignment as
    // "offset is a multiple of size", lanes filled byte by byte.
    function automatic vec_t model(input logic [31:0] addr, data, input logic rd, wr,
                                   input logic [1:0] mask, input int rdy, rv,
                                   input logic [31:0] rdata, prev);
        vec_t e;
        int size;
        int off;
        size = (mask == 2'b00) ? 1 : (mask == 2'b01) ? 2 : 4;
        off  = int'(addr[1:0]);
        e.addr = addr; e.data = data; e.rd = rd; e.wr = wr; e.mask = mask;
        e.rdy = rdy;   e.rv = rv;     e.rdata = rdata;
        e.we    = wr;
        e.baddr = addr & 32'hFFFF_FFFC;
        e.strb  = 4'b0000;
        e.wdata = '0;
        for (int k = 0; k < 4; k++) e.wdata[8*k +: 8] = data[8*(k % size) +: 8];
        e.mis = (off % size) != 0;
        e.err = 1'b0;
        e.rdv = prev;
        if (wr && !e.mis) begin
            for (int i = 0; i < size; i++) e.strb[off + i] = 1'b1;
        end
        if (e.mis) begin
            e.stall = 1; e.vcyc = 0; e.rdv = '0;
        end else if (rdy >= T) begin
            e.stall = 1 + T; e.vcyc = T; e.err = 1'b1; e.rdv = '0;
        end else if (wr) begin
            e.stall = 2 + rdy; e.vcyc = rdy + 1;
        end else if (rv >= T) begin
            e.stall = 2 + rdy + T; e.vcyc = rdy + 1; e.err = 1'b1; e.rdv = '0;
        end else begin
            e.stall = 3 + rdy + rv; e.vcyc = rdy + 1; e.rdv = '0;
            for (int i = 0; i < size; i++) e.rdv[8*i +: 8] = rdata[8*(off + i) +: 8];
        end
        return e;
    endfunction

    // Called just after a rising edge; returns just after a rising edge.
    task automatic run_txn(input vec_t v, input string tag);
        int stall_cyc = 0;
        int vcyc = 0;
        int req_wait = 0;
        int rsp_wait = 0;
        bit in_resp = 1'b0;
        bit done = 1'b0;
        bit accept;
        bit was_valid;
        bit was_resp;
        i_addr = v.addr; i_write_data = v.data; i_data_mask = v.mask;
        i_read_en = v.rd; i_write_en = v.wr;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            i_bus_ready  = 1'b0;
            i_bus_rvalid = 1'b0;
            if (o_stall) stall_cyc++;
            else done = 1'b1;
            was_valid = o_bus_valid;
            if (o_bus_valid) begin
                vcyc++;
                check($sformatf("%s bus_addr", tag), o_bus_addr, v.baddr);
                check($sformatf("%s bus_we", tag), 32'(o_bus_we), 32'(v.we));
                check($sformatf("%s wstrb", tag), 32'(o_bus_wstrb), 32'(v.strb));
                if (v.we) check($sformatf("%s wdata", tag), o_bus_wdata, v.wdata);
                i_bus_ready = (req_wait == v.rdy);
            end
            if (in_resp) begin
                i_bus_rvalid = (rsp_wait == v.rv);
                i_bus_rdata  = v.rdata;
            end
            accept   = was_valid && i_bus_ready;
            was_resp = in_resp;
            if (done) begin
                check($sformatf("%s stall_cycles", tag), 32'(stall_cyc), 32'(v.stall));
                check($sformatf("%s valid_cycles", tag), 32'(vcyc), 32'(v.vcyc));
                check($sformatf("%s misaligned", tag), 32'(o_misaligned), 32'(v.mis));
                check($sformatf("%s bus_error", tag), 32'(o_bus_error), 32'(v.err));
                check($sformatf("%s read_data", tag), o_read_data, v.rdv);
            end
            @(posedge clk);
            #1;
            if (was_resp) rsp_wait++;
            if (accept && !v.we) in_resp = 1'b1;
            if (was_valid && !accept) req_wait++;
        end
        check($sformatf("%s completed", tag), 32'(done), 32'd1);
        i_read_en = 1'b0; i_write_en = 1'b0; i_bus_ready = 1'b0; i_bus_rvalid = 1'b0;
        @(negedge clk);
        check($sformatf("%s pulse_end", tag), {29'd0, o_misaligned, o_bus_error, o_stall}, 32'd0);
        check($sformatf("%s read_hold", tag), o_read_data, v.rdv);
        @(posedge clk);
        #1;
        rd_hold = v.rdv;
    endtask

    // Idle cycles with stray rvalid: must not disturb anything.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            i_bus_rvalid = 1'($urandom_range(0, 1));
            i_bus_rdata  = $urandom();
            @(negedge clk);
            check("idle stall_valid", {30'd0, o_stall, o_bus_valid}, 32'd0);
            check("idle read_data", o_read_data, rd_hold);
            @(posedge clk);
            #1;
        end
        i_bus_rvalid = 1'b0;
    endtask

    vec_t tbl[12];

    initial begin
        rst = 1'b1;
        i_addr = '0; i_write_data = '0; i_read_en = 1'b0; i_write_en = 1'b0;
        i_data_mask = 2'b00; i_bus_ready = 1'b0; i_bus_rvalid = 1'b0; i_bus_rdata = '0;
        rd_hold = '0;

        //           addr          data          rd wr mask  rdy rv rdata         stall vc mis err baddr         strb     wdata         rdv
        tbl[0]  = mk(32'h0000_0104, 32'hDEAD_BEEF, 0, 1, 2'b10, 0, 0, 32'h0,         2, 1, 0, 0, 32'h0000_0104, 4'b1111, 32'hDEAD_BEEF, 32'h0);
        tbl[1]  = mk(32'h0000_0103, 32'h0000_00AB, 0, 1, 2'b00, 0, 0, 32'h0,         2, 1, 0, 0, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 32'h0);
        tbl[2]  = mk(32'h0000_0202, 32'h0,         1, 0, 2'b01, 0, 3, 32'h1234_5678, 6, 1, 0, 0, 32'h0000_0200, 4'b0000, 32'h0,         32'h0000_1234);
        tbl[3]  = mk(32'h0000_0101, 32'h0,         1, 0, 2'b10, 0, 0, 32'h0,         1, 0, 1, 0, 32'h0,         4'b0000, 32'h0,         32'h0);
        tbl[4]  = mk(32'h0000_0200, 32'h5555_AAAA, 0, 1, 2'b10, 4, 0, 32'h0,         5, 4, 0, 1, 32'h0000_0200, 4'b1111, 32'h5555_AAAA, 32'h0);
        tbl[5]  = mk(32'h0000_0301, 32'h0,         1, 0, 2'b00, 1, 0, 32'hA1B2_C3D4, 4, 2, 0, 0, 32'h0000_0300, 4'b0000, 32'h0,         32'h0000_00C3);
        tbl[6]  = mk(32'h0000_0400, 32'h0,         1, 0, 2'b10, 0, 4, 32'h7777_7777, 6, 1, 0, 1, 32'h0000_0400, 4'b0000, 32'h0,         32'h0);
        tbl[7]  = mk(32'h0000_0500, 32'h0,         1, 0, 2'b10, 0, 0, 32'hCAFE_F00D, 3, 1, 0, 0, 32'h0000_0500, 4'b0000, 32'h0,         32'hCAFE_F00D);
        tbl[8]  = mk(32'h0000_0106, 32'h0000_BEEF, 0, 1, 2'b01, 0, 0, 32'h0,         2, 1, 0, 0, 32'h0000_0104, 4'b1100, 32'hBEEF_BEEF, 32'hCAFE_F00D);
        tbl[9]  = mk(32'h0000_0010, 32'h1122_3344, 0, 1, 2'b11, 0, 0, 32'h0,         2, 1, 0, 0, 32'h0000_0010, 4'b1111, 32'h1122_3344, 32'hCAFE_F00D);
        tbl[10] = mk(32'h0000_0002, 32'h0000_005A, 1, 1, 2'b00, 0, 0, 32'h0,         2, 1, 0, 0, 32'h0000_0000, 4'b0100, 32'h5A5A_5A5A, 32'hCAFE_F00D);
        tbl[11] = mk(32'h0000_0203, 32'h0,         1, 0, 2'b01, 0, 0, 32'h0,         1, 0, 1, 0, 32'h0,         4'b0000, 32'h0,         32'h0);

        // Reset state.
        @(posedge clk);
        @(negedge clk);
        check("reset read_data", o_read_data, 32'h0);
        check("reset flags", {27'd0, o_stall, o_misaligned, o_bus_error, o_bus_valid, o_bus_we}, 32'h0);
        check("reset bus_addr", o_bus_addr, 32'h0);
        check("reset wstrb", 32'(o_bus_wstrb), 32'h0);
        check("reset wdata", o_bus_wdata, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_cycles(2);

        foreach (tbl[i]) begin
            run_txn(tbl[i], $sformatf("vec%0d", i));
        end

        for (int n = 0; n < 150; n++) begin
            logic [1:0]  sel;
            logic [31:0] a;
            sel = 2'($urandom_range(1, 3));
            a   = $urandom();
            run_txn(model(a, $urandom(), sel[0], sel[1], 2'($urandom_range(0, 3)),
                          $urandom_range(0, 5), $urandom_range(0, 5), $urandom(), rd_hold),
                    $sformatf("rnd%0d", n));
            idle_cycles($urandom_range(0, 2));
        end

        // Reset while a load waits in RESP; a later rvalid must be ignored.
        run_txn(model(32'h0000_0700, 32'h0, 1'b1, 1'b0, 2'b10, 0, 0, 32'h89AB_CDEF, rd_hold), "pre_rst");
        i_addr = 32'h0000_0600; i_data_mask = 2'b10; i_read_en = 1'b1;
        @(negedge clk);
        check("rst_seq idle_stall", 32'(o_stall), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_seq req_valid", 32'(o_bus_valid), 32'd1);
        i_bus_ready = 1'b1;
        @(posedge clk);
        #1;
        i_bus_ready = 1'b0;
        @(negedge clk);
        check("rst_seq resp_stall", {30'd0, o_stall, o_bus_valid}, 32'b10);
        rst = 1'b1;
        i_read_en = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        i_bus_rvalid = 1'b1;
        i_bus_rdata  = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_seq flags", {27'd0, o_stall, o_misaligned, o_bus_error, o_bus_valid, o_bus_we}, 32'h0);
            check("rst_seq read_data", o_read_data, 32'h0);
            check("rst_seq bus_addr", o_bus_addr, 32'h0);
            @(posedge clk);
            #1;
        end
        i_bus_rvalid = 1'b0;
        rd_hold = '0;
        run_txn(model(32'h0000_0602, 32'h0, 1'b1, 1'b0, 2'b01, 1, 1, 32'hBEEF_0042, rd_hold), "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
